// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host initiator.
package wb_host_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating bus-cycle counter; expired is high for the one cycle in which
// the count sits at TIMEOUT_CYCLES-1.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt;

  // expired is registered alongside the count so it aligns with cnt == LAST
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      if (cnt != LAST) cnt <= cnt + CW'(1);
      expired <= (cnt == PRE);
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_host_initiator.sv
// Single-transfer Wishbone classic initiator with command/response handshakes
// and a bus timeout for responders that never acknowledge.
module wb_host_initiator
  import wb_host_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [WB_DW-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_SELW-1:0] cmd_sel,
  input  logic [WB_DW-1:0]   cmd_adr,
  input  logic [WB_DW-1:0]   cmd_dat,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_DW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i
);

  state_e state;
  logic   ack_clean_c;
  logic   cnt_clear_c;
  logic   cnt_enable_c;
  logic   expired;

  // An undriven (Z) or unknown ack from a deselected slot must not count
  assign ack_clean_c  = (wbm_ack_i === 1'b1);
  assign cnt_clear_c  = (state != BUS);
  assign cnt_enable_c = (state == BUS) && !ack_clean_c;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (cnt_clear_c),
    .enable  (cnt_enable_c),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing in the same cycle
          if (ack_clean_c) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= ERR_DATA;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized transfers checked against a transaction-level model.
module tb_wb_host_initiator;

  localparam int unsigned T = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic        ack;
  logic [31:0] dat_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_host_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we_o),
    .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o),
    .wbm_dat_o(dat_o),
    .wbm_ack_i(ack),
    .wbm_dat_i(dat_i)
  );

  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          ack_at;   // BUS cycle carrying ack; 0 = never
    logic [31:0] rd;
    int          hold;     // cycles rsp_ready stays low
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: ack within the window wins, else timeout
  function automatic void model(input bit we, input int ack_at, input logic [31:0] rd,
                                output int ncyc, output bit err, output logic [31:0] d);
    if (ack_at >= 1 && ack_at <= int'(T)) begin
      ncyc = ack_at;
      err  = 1'b0;
      d    = we ? 32'h0 : rd;
    end else begin
      ncyc = int'(T);
      err  = 1'b1;
      d    = ERR;
    end
  endfunction

  task automatic run_txn(input vec_t v);
    int n;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_sel   = v.sel;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    tick();
    cmd_valid = 1'b0;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = 4'($urandom);
    cmd_we    = ~v.we;
    n = 0;
    while (cyc === 1'b1 && n < int'(T) + 4) begin
      chk("bus_ctl", {27'd0, stb, we_o, sel_o}, {27'd0, 1'b1, v.we, v.sel});
      chk("bus_adr", adr_o, v.adr);
      chk("bus_wdat", dat_o, v.dat);
      chk("bus_flags", {30'd0, cmd_ready, rsp_valid}, 32'd0);
      n++;
      ack   = (n == v.ack_at) ? 1'b1 : 1'bz;
      dat_i = (n == v.ack_at) ? v.rd : $urandom;
      tick();
      ack = 1'b0;
    end
    chk("cyc_cycles", 32'(n), 32'(v.exp_cyc));
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_dat", rsp_dat, v.exp_dat);
    chk("stb_low", 32'(stb), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      ack = 1'b1;
      dat_i = $urandom;
      tick();
      chk("hold_ctl", {29'd0, cmd_ready, cyc, rsp_valid}, 32'd1);
      chk("hold_dat", rsp_dat, v.exp_dat);
      chk("hold_err", 32'(rsp_err), 32'(v.exp_err));
    end
    cmd_valid = 1'b0;
    ack = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("adr_kept", adr_o, v.adr);
  endtask

  initial begin
    vec_t r;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0;
    cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;

    vecs[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0F0F, 3, 32'h5555_5555, 0, 3, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         1, 32'h1234_5678, 0, 1, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 4'h3, 32'h3000_0010, 32'h0,         0, 32'h0,         0, 8, 1'b1, ERR};
    vecs[3] = '{1'b0, 4'hC, 32'h3000_0020, 32'h0,         8, 32'hCAFE_F00D, 0, 8, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0,         2, 32'h0BAD_C0DE, 5, 2, 1'b0, 32'h0BAD_C0DE};
    vecs[5] = '{1'b1, 4'h1, 32'h3000_00FC, 32'h0000_00AA, 9, 32'h7777_7777, 1, 8, 1'b1, ERR};

    tick(); tick();
    chk("rst_ctl", {26'd0, cmd_ready, rsp_valid, rsp_err, cyc, stb, we_o}, {26'd0, 6'b100000});
    chk("rst_rsp_dat", rsp_dat, 32'h0);
    chk("rst_bus", {sel_o, adr_o[27:0]} ^ dat_o, 32'h0);
    chk("rst_adr", adr_o, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Stray ack while idle must not produce a response
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dat_i = $urandom;
      tick();
      chk("stray_ack", {29'd0, cmd_ready, cyc, rsp_valid}, 32'd4);
    end
    ack = 1'b0;

    // Reset during BUS discards the transfer
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_cyc", 32'(cyc), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_bus_ctl", {28'd0, cmd_ready, cyc, stb, rsp_valid}, 32'd8);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rst_bus_late_ack", {29'd0, cmd_ready, cyc, rsp_valid}, 32'd4);
    r = '{1'b0, 4'hF, 32'h3000_0044, 32'h0, 2, 32'h600D_DA7A, 0, 2, 1'b0, 32'h600D_DA7A};
    run_txn(r);

    // Reset during RESP clears rsp_valid
    cmd_valid = 1'b1; cmd_we = 1'b0;
    tick();
    cmd_valid = 1'b0;
    ack = 1'b1; dat_i = 32'h1111_2222;
    tick();
    ack = 1'b0;
    chk("resp_before_rst", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_resp_ctl", {30'd0, cmd_ready, rsp_valid}, 32'd2);

    // Randomized transfers against the model
    for (int i = 0; i < 30; i++) begin
      r.we     = 1'($urandom);
      r.sel    = 4'($urandom);
      r.adr    = $urandom;
      r.dat    = $urandom;
      r.ack_at = int'($urandom_range(0, 10));
      r.rd     = $urandom;
      r.hold   = int'($urandom_range(0, 3));
      model(r.we, r.ack_at, r.rd, r.exp_cyc, r.exp_err, r.exp_dat);
      run_txn(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_host_initiator.md
Name: wb_host_initiator

Overview:
Wishbone classic (B3, single-transfer) initiator that drives a project slot's responder port (stb/cyc/we/sel/adr/dat in, ack/dat out).
- Takes one command at a time from a valid/ready command port, runs one bus cycle, and returns read data or a timeout error on a valid/ready response port.
- Used by the harness test logic to exercise the Wishbone port of each tristated project wrapper. A deselected slot leaves ack undriven, so a timeout is mandatory.

Parameters:
TIMEOUT_CYCLES, 255, max cycles with cyc asserted before the transfer is abandoned (range 2..65535)
ERR_DATA, 32'hDEAD_BEEF, value returned on rsp_dat when a timeout occurs

Ports:
wb_clk_i  input  1  single clock, rising edge
wb_rst_ni  input  1  synchronous reset, active-low
cmd_valid  input  1  command offered
cmd_ready  output  1  initiator can accept a command
cmd_we  input  1  1 = write, 0 = read
cmd_sel  input  4  byte selects
cmd_adr  input  32  byte address
cmd_dat  input  32  write data
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_dat  output  32  read data; 0 for a successful write; ERR_DATA on timeout
rsp_err  output  1  1 = transfer timed out
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte selects
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_ack_i  input  1  Wishbone acknowledge (X/Z tolerant: only a clean 1 counts)
wbm_dat_i  input  32  Wishbone read data

Behaviour:
- Reset (wb_rst_ni low at a rising edge):
  - state IDLE; cmd_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_dat=0.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0.
  - Timeout counter=0.
- All outputs are registered. cmd_ready is 1 only in IDLE.
- IDLE:
  - On cmd_valid&&cmd_ready at edge N, latch we/sel/adr/dat into the wbm_* registers.
  - Assert wbm_cyc_o=wbm_stb_o=1 from cycle N+1. Counter=0. Go to BUS.
- BUS: wbm_cyc_o, wbm_stb_o and the address/data/sel/we outputs stay stable until the transfer ends.
  - Ack: wbm_ack_i==1 at edge M:
    - Deassert cyc/stb at M+1.
    - rsp_dat = wbm_dat_i for a read, 0 for a write; rsp_err=0; rsp_valid=1 at M+1.
    - Go to RESP.
    - Minimum command-to-response latency is 2 cycles (ack in first BUS cycle).
  - No ack:
    - Counter increments.
    - When the counter reaches TIMEOUT_CYCLES-1 with no ack, deassert cyc/stb next cycle and set rsp_err=1, rsp_dat=ERR_DATA, rsp_valid=1. Go to RESP.
    - cyc is therefore high for exactly TIMEOUT_CYCLES cycles.
  - Ack on the timeout cycle: ack wins, rsp_err=0.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that edge, clear rsp_valid and return to IDLE (cmd_ready=1 next cycle).
  - No new command is accepted while in RESP; there is no pipelining.
- wbm_ack_i outside BUS is ignored (a stale or late ack must not create a response).
- wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their last values after the cycle ends. Only cyc/stb matter to the responder.
- Reset mid-BUS: cyc/stb are low the cycle after the reset edge and the response is discarded. Reset mid-RESP: rsp_valid is cleared.
- Counter width: clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Decomposition:
- Shared package wb_host_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - constant WB_DW=32;
  - constant WB_SELW=4;
  - default ERR_DATA.
- One sub-module, wb_timeout_counter (params TIMEOUT_CYCLES).
  - Inputs: clear, enable.
  - Output: expired, a one-cycle pulse on reaching TIMEOUT_CYCLES-1.
- FSM and datapath stay in wb_host_initiator.

Test Plan:
- Write adr=0x3000_0004, dat=0xA5A5_0F0F, sel=0xF; responder acks on 3rd BUS cycle -> cyc high 3 cycles, outputs stable throughout; rsp_valid with rsp_dat=0, rsp_err=0.
- Read adr=0x3000_0000; responder returns 0x1234_5678 with ack on 1st BUS cycle -> rsp_valid exactly 2 cycles after the cmd handshake, rsp_dat=0x1234_5678.
- TIMEOUT_CYCLES=8, ack tied to Z -> cyc high exactly 8 cycles; rsp_err=1, rsp_dat=0xDEAD_BEEF.
- TIMEOUT_CYCLES=8, ack on the 8th BUS cycle -> rsp_err=0, read data returned. A stray ack pulse while in IDLE -> no rsp_valid.
- rsp_ready held low 5 cycles after a read -> rsp_valid/rsp_dat stable, cmd_ready=0, a second cmd_valid is not accepted. It is accepted on the first IDLE cycle after the handshake.
- wb_rst_ni low for 1 cycle during BUS -> cyc/stb=0 the next cycle, no response, cmd_ready=1; a new read then completes normally.
